// File: rtl/mips_core_pkg.sv
// Shared integer-pipeline types: ALU control, branch outcome and the issue-queue entry record.
package mips_core_pkg;

    localparam int PREG_IDX_W = 6;
    localparam int DATA_W_P   = 32;
    localparam int ADDR_W_P   = 32;
    localparam int AL_IDX_W   = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11,
        ALU_PASS = 4'd12
    } AluCtl;

    typedef enum logic [0:0] {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;

    typedef struct packed {
        logic [PREG_IDX_W-1:0] src1;
        logic [PREG_IDX_W-1:0] src2;
        logic [DATA_W_P-1:0]   imm;
        AluCtl                 alu_ctl;
        logic                  is_branch;
        BranchOutcome          prediction;
        logic [ADDR_W_P-1:0]   recovery;
        logic                  uses_rs;
        logic                  uses_rt;
        logic                  uses_imm;
        logic [AL_IDX_W-1:0]   al_id;
    } int_issue_entry_t;

    // Idle dispatch register contents: everything zero except the static "taken" prediction.
    function automatic int_issue_entry_t entry_reset_value();
        int_issue_entry_t e;
        e            = '0;
        e.prediction = TAKEN;
        return e;
    endfunction

endpackage

// File: rtl/int_issue_select_rr_arbiter.sv
// Round-robin arbiter: rotates the request vector by ptr (double-width shift) and priority-encodes it.
module rr_arbiter #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [N-1:0]     rot_s;
    logic [IDX_W-1:0] off_s;

    // Lowest set bit of the rotated vector is the first requester at or after ptr.
    always_comb begin
        rot_s = N'({req, req} >> ptr);
        off_s = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot_s[k]) begin
                off_s = IDX_W'(k);
            end else begin
                off_s = off_s;
            end
        end
        any   = |req;
        idx   = ptr + off_s;
        grant = '0;
        if (any) begin
            grant[idx] = 1'b1;
        end else begin
            grant = '0;
        end
    end

endmodule

// File: rtl/int_issue_select.sv
// Integer issue select/dispatch: round-robin pick of a ready entry into a valid/ready output register.
// Optional same-cycle writeback wakeup bypass: define ISSUE_SEL_WAKEUP_BYPASS_EN.
module int_issue_select
    import mips_core_pkg::*;
#(
    parameter int QUEUE_SIZE = 8,
    parameter int PREG_IDX   = PREG_IDX_W,
    parameter int DATA_W     = DATA_W_P,
    parameter int ADDR_W     = ADDR_W_P,
    parameter int AL_IDX     = AL_IDX_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [QUEUE_SIZE-1:0]        q_occupied,
    input  logic [QUEUE_SIZE-1:0]        q_rdy1,
    input  logic [QUEUE_SIZE-1:0]        q_rdy2,
    input  logic [QUEUE_SIZE*PREG_IDX-1:0] q_src1,
    input  logic [QUEUE_SIZE*PREG_IDX-1:0] q_src2,
    input  logic [QUEUE_SIZE*DATA_W-1:0] q_imm,
    input  AluCtl                        q_alu_ctl [QUEUE_SIZE],
    input  logic [QUEUE_SIZE-1:0]        q_is_branch,
    input  BranchOutcome                 q_prediction [QUEUE_SIZE],
    input  logic [QUEUE_SIZE*ADDR_W-1:0] q_recovery,
    input  logic [QUEUE_SIZE-1:0]        q_uses_rs,
    input  logic [QUEUE_SIZE-1:0]        q_uses_rt,
    input  logic [QUEUE_SIZE-1:0]        q_uses_imm,
    input  logic [QUEUE_SIZE*AL_IDX-1:0] q_al_id,
    input  logic                         wb_valid,
    input  logic [PREG_IDX-1:0]          wb_tag,
    output logic [QUEUE_SIZE-1:0]        grant_clear,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [PREG_IDX-1:0]          out_src1,
    output logic [PREG_IDX-1:0]          out_src2,
    output logic [DATA_W-1:0]            out_imm,
    output AluCtl                        out_alu_ctl,
    output logic                         out_is_branch,
    output BranchOutcome                 out_prediction,
    output logic [ADDR_W-1:0]            out_recovery,
    output logic                         out_uses_rs,
    output logic                         out_uses_rt,
    output logic                         out_uses_imm,
    output logic [AL_IDX-1:0]            out_al_id
);

    localparam int IDX_W = $clog2(QUEUE_SIZE);

    int_issue_entry_t        entry_s [QUEUE_SIZE];
    logic [QUEUE_SIZE-1:0]   rdy1_eff_s;
    logic [QUEUE_SIZE-1:0]   rdy2_eff_s;
    logic [QUEUE_SIZE-1:0]   req_s;
    logic [QUEUE_SIZE-1:0]   grant_s;
    logic [IDX_W-1:0]        sel_s;
    logic                    any_s;
    logic                    slot_free_s;
    logic                    fire_s;

    int_issue_entry_t        out_entry_d, out_entry_q;
    logic                    out_valid_d, out_valid_q;
    logic [IDX_W-1:0]        rr_ptr_d, rr_ptr_q;

    // Unflatten the queue's per-entry fields into entry records.
    always_comb begin
        for (int i = 0; i < QUEUE_SIZE; i++) begin
            entry_s[i].src1       = q_src1[i*PREG_IDX +: PREG_IDX];
            entry_s[i].src2       = q_src2[i*PREG_IDX +: PREG_IDX];
            entry_s[i].imm        = q_imm[i*DATA_W +: DATA_W];
            entry_s[i].alu_ctl    = q_alu_ctl[i];
            entry_s[i].is_branch  = q_is_branch[i];
            entry_s[i].prediction = q_prediction[i];
            entry_s[i].recovery   = q_recovery[i*ADDR_W +: ADDR_W];
            entry_s[i].uses_rs    = q_uses_rs[i];
            entry_s[i].uses_rt    = q_uses_rt[i];
            entry_s[i].uses_imm   = q_uses_imm[i];
            entry_s[i].al_id      = q_al_id[i*AL_IDX +: AL_IDX];
        end
    end

`ifdef ISSUE_SEL_WAKEUP_BYPASS_EN
    // A matching writeback tag this cycle counts as ready, so the consumer can issue immediately.
    always_comb begin
        for (int i = 0; i < QUEUE_SIZE; i++) begin
            rdy1_eff_s[i] = q_rdy1[i] |
                            (wb_valid & q_uses_rs[i] & (q_src1[i*PREG_IDX +: PREG_IDX] == wb_tag));
            rdy2_eff_s[i] = q_rdy2[i] |
                            (wb_valid & q_uses_rt[i] & (q_src2[i*PREG_IDX +: PREG_IDX] == wb_tag));
        end
    end
`else
    logic unused_wb_s;
    assign unused_wb_s = ^{wb_valid, wb_tag};
    assign rdy1_eff_s  = q_rdy1;
    assign rdy2_eff_s  = q_rdy2;
`endif

    assign req_s = q_occupied & rdy1_eff_s & rdy2_eff_s;

    rr_arbiter #(
        .N     (QUEUE_SIZE),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req   (req_s),
        .ptr   (rr_ptr_q),
        .grant (grant_s),
        .idx   (sel_s),
        .any   (any_s)
    );

    // Fire decision and next-state; grant_clear is suppressed under reset so the queue frees nothing.
    always_comb begin
        slot_free_s = ~out_valid_q | out_ready;
        fire_s      = slot_free_s & any_s & ~flush & ~rst;
        out_entry_d = out_entry_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (fire_s) begin
            grant_clear = grant_s;
            out_entry_d = entry_s[sel_s];
            out_valid_d = 1'b1;
            rr_ptr_d    = sel_s + IDX_W'(1);
        end else if (flush | out_ready) begin
            grant_clear = '0;
            out_valid_d = 1'b0;
        end else begin
            grant_clear = '0;
        end
    end

    // Dispatch register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
            out_entry_q <= entry_reset_value();
        end else begin
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
            out_entry_q <= out_entry_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_src1       = out_entry_q.src1;
    assign out_src2       = out_entry_q.src2;
    assign out_imm        = out_entry_q.imm;
    assign out_alu_ctl    = out_entry_q.alu_ctl;
    assign out_is_branch  = out_entry_q.is_branch;
    assign out_prediction = out_entry_q.prediction;
    assign out_recovery   = out_entry_q.recovery;
    assign out_uses_rs    = out_entry_q.uses_rs;
    assign out_uses_rt    = out_entry_q.uses_rt;
    assign out_uses_imm   = out_entry_q.uses_imm;
    assign out_al_id      = out_entry_q.al_id;

endmodule

// File: tb/tb_int_issue_select.sv
// Directed bench for int_issue_select; dispatched entries are checked by a scoreboard monitor.
module tb_int_issue_select;
    import mips_core_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic [7:0]      q_occupied, q_rdy1, q_rdy2;
    logic [47:0]     q_src1, q_src2;
    logic [255:0]    q_imm;
    AluCtl           q_alu_ctl [8];
    logic [7:0]      q_is_branch;
    BranchOutcome    q_prediction [8];
    logic [255:0]    q_recovery;
    logic [7:0]      q_uses_rs, q_uses_rt, q_uses_imm;
    logic [39:0]     q_al_id;
    logic            wb_valid;
    logic [5:0]      wb_tag;
    logic [7:0]      grant_clear;
    logic            out_valid;
    logic            out_ready;
    logic [5:0]      out_src1, out_src2;
    logic [31:0]     out_imm;
    AluCtl           out_alu_ctl;
    logic            out_is_branch;
    BranchOutcome    out_prediction;
    logic [31:0]     out_recovery;
    logic            out_uses_rs, out_uses_rt, out_uses_imm;
    logic [4:0]      out_al_id;

    int              n_tests = 0;
    int              n_fail  = 0;
    logic [127:0]    exp_q [$];

    int_issue_select dut (
        .clk(clk), .rst(rst), .flush(flush),
        .q_occupied(q_occupied), .q_rdy1(q_rdy1), .q_rdy2(q_rdy2),
        .q_src1(q_src1), .q_src2(q_src2), .q_imm(q_imm),
        .q_alu_ctl(q_alu_ctl), .q_is_branch(q_is_branch), .q_prediction(q_prediction),
        .q_recovery(q_recovery), .q_uses_rs(q_uses_rs), .q_uses_rt(q_uses_rt),
        .q_uses_imm(q_uses_imm), .q_al_id(q_al_id),
        .wb_valid(wb_valid), .wb_tag(wb_tag),
        .grant_clear(grant_clear), .out_valid(out_valid), .out_ready(out_ready),
        .out_src1(out_src1), .out_src2(out_src2), .out_imm(out_imm),
        .out_alu_ctl(out_alu_ctl), .out_is_branch(out_is_branch),
        .out_prediction(out_prediction), .out_recovery(out_recovery),
        .out_uses_rs(out_uses_rs), .out_uses_rt(out_uses_rt),
        .out_uses_imm(out_uses_imm), .out_al_id(out_al_id)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] exp_key(input int i);
        return {38'd0, q_src1[i*6 +: 6], q_src2[i*6 +: 6], q_imm[i*32 +: 32], q_alu_ctl[i],
                q_is_branch[i], q_prediction[i], q_recovery[i*32 +: 32],
                q_uses_rs[i], q_uses_rt[i], q_uses_imm[i], q_al_id[i*5 +: 5]};
    endfunction

    function automatic logic [127:0] out_key();
        return {38'd0, out_src1, out_src2, out_imm, out_alu_ctl, out_is_branch, out_prediction,
                out_recovery, out_uses_rs, out_uses_rt, out_uses_imm, out_al_id};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Scoreboard monitor: every transfer must match the oldest expected entry.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL xfer_unexpected: got %0h expected no transfer", out_key());
            end else begin
                chk("xfer_fields", out_key(), exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1; wb_valid = 1'b0; wb_tag = 6'h00;
        q_occupied = 8'hFF; q_rdy1 = 8'hFF; q_rdy2 = 8'hFF;
        q_uses_rs = 8'hFF; q_uses_rt = 8'h55; q_uses_imm = 8'hAA;
        for (int i = 0; i < 8; i++) begin
            q_src1[i*6 +: 6]      = 6'(i + 1);
            q_src2[i*6 +: 6]      = 6'(i + 32);
            q_imm[i*32 +: 32]     = 32'hA000_0000 | 32'(i);
            q_alu_ctl[i]          = AluCtl'(4'(i + 1));
            q_is_branch[i]        = i[0];
            q_prediction[i]       = BranchOutcome'(i[1]);
            q_recovery[i*32 +: 32] = 32'h0040_0000 + 32'(i * 4);
            q_al_id[i*5 +: 5]     = 5'(i + 3);
        end

        // 1: reset holds everything idle even with a full ready queue
        tick(); tick();
        #1;
        chk("rst_grant", 128'(grant_clear), 128'h00);
        chk("rst_valid", 128'(out_valid), 128'h0);
        chk("rst_pred", 128'(out_prediction), 128'(TAKEN));
        chk("rst_al_id", 128'(out_al_id), 128'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("first_grant", 128'(grant_clear), 128'h01);
        exp_q.push_back(exp_key(0));
        tick();
        q_occupied = 8'h00;
        #1;
        chk("first_valid", 128'(out_valid), 128'h1);
        tick();
        q_occupied = 8'h04;
        #1;
        chk("grant_2", 128'(grant_clear), 128'h04);
        exp_q.push_back(exp_key(2));

        // 2: rr_ptr=3 with entries 2,5 -> 5 then wrap to 2 back-to-back
        tick();
        q_occupied = 8'h24;
        #1;
        chk("rr_pick5", 128'(grant_clear), 128'h20);
        exp_q.push_back(exp_key(5));
        tick();
        q_occupied = 8'h04;
        #1;
        chk("rr_wrap2", 128'(grant_clear), 128'h04);
        exp_q.push_back(exp_key(2));

        // 3: load entry 1, stall 3 cycles, then same-edge transfer and load of 4
        tick();
        q_occupied = 8'h02;
        #1;
        chk("grant_1", 128'(grant_clear), 128'h02);
        exp_q.push_back(exp_key(1));
        for (int c = 0; c < 3; c++) begin
            tick();
            out_ready  = 1'b0;
            q_occupied = 8'h10;
            #1;
            chk("stall_grant", 128'(grant_clear), 128'h00);
            chk("stall_valid", 128'(out_valid), 128'h1);
            chk("stall_hold", out_key(), exp_key(1));
        end
        tick();
        out_ready = 1'b1;
        #1;
        chk("xfer_load4", 128'(grant_clear), 128'h10);
        exp_q.push_back(exp_key(4));

        // 4: flush with out_valid=1 and entry 3 ready
        tick();
        q_occupied = 8'h08;
        out_ready  = 1'b0;
        flush      = 1'b1;
        #1;
        chk("flush_valid_before", 128'(out_valid), 128'h1);
        chk("flush_grant", 128'(grant_clear), 128'h00);
        void'(exp_q.pop_back());
        tick();
        flush      = 1'b0;
        out_ready  = 1'b1;
        q_occupied = 8'h30;
        #1;
        chk("flush_valid_after", 128'(out_valid), 128'h0);
        chk("flush_rr_held", 128'(grant_clear), 128'h20);
        exp_q.push_back(exp_key(5));

        // 5: wakeup bypass on entry 6 source 1
        tick();
        q_occupied       = 8'h40;
        q_rdy1           = 8'hBF;
        q_src1[6*6 +: 6] = 6'h11;
        wb_valid         = 1'b1;
        wb_tag           = 6'h12;
        #1;
        chk("bypass_tag_miss", 128'(grant_clear), 128'h00);
        wb_tag = 6'h11;
        #1;
`ifdef ISSUE_SEL_WAKEUP_BYPASS_EN
        chk("bypass_hit", 128'(grant_clear), 128'h40);
        exp_q.push_back(exp_key(6));
`else
        chk("bypass_ignored", 128'(grant_clear), 128'h00);
`endif

        // 6: reset during a stall with out_valid=1
        tick();
        wb_valid   = 1'b0;
        q_rdy1     = 8'hFF;
        q_occupied = 8'h02;
        #1;
        chk("grant_1b", 128'(grant_clear), 128'h02);
        exp_q.push_back(exp_key(1));
        tick();
        q_occupied = 8'h04;
        out_ready  = 1'b0;
        rst        = 1'b1;
        #1;
        chk("rst_stall_valid", 128'(out_valid), 128'h1);
        chk("rst_stall_grant", 128'(grant_clear), 128'h00);
        void'(exp_q.pop_back());
        tick();
        rst        = 1'b0;
        q_occupied = 8'hFF;
        #1;
        chk("post_rst_valid", 128'(out_valid), 128'h0);
        chk("post_rst_ptr0", 128'(grant_clear), 128'h01);
        exp_q.push_back(exp_key(0));
        tick();
        q_occupied = 8'h00;
        out_ready  = 1'b1;
        #1;
        chk("post_rst_load", 128'(out_valid), 128'h1);
        tick();
        tick();
        chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
